fwd_unit_pipe: RTL and testbench
================================

Name: fwd_unit_pipe

Overview:
- Parametrised successor to the combinational EXE-stage forwarding unit.
- Holds its own shadow pipeline of NSTAGE in-flight write descriptors (result, flags, Fmask) captured from EXE, so forwarding depth no longer depends on external MEM/WB wiring.
- Serves NSRC source operands with byte-wise pair/half forwarding and bit-wise F merging, and detects load-use hazards against outstanding loads.
- Drives a pipeline Stall and a saturating stall-cycle counter.

Parameters:
- NSRC, 2, number of ALU source operands served (1..4).
- NSTAGE, 2, shadow-pipe depth; stage 0 is youngest (MEM position), stage NSTAGE-1 is oldest (1..4).
- CNTW, 16, width of the stall-cycle counter.

Ports:
- Clk  in  1  system clock; one clock domain; all state updates on the rising edge.
- Rst_n  in  1  reset, asynchronous and active-low.
- Rd_id  in  5*NSRC  register ids of the source operands; operand n is bits [5n+4:5n].
- Rd_data  in  16*NSRC  register-file values of the source operands.
- Rd_valid  in  NSRC  the operand is actually consumed; used for hazard detection only.
- Ex_valid  in  1  the EXE instruction writes a result.
- Ex_wr_id  in  5  destination id of the EXE write.
- Ex_result  in  16  EXE ALU result.
- Ex_flags  in  8  flag values from EXE.
- Ex_fmask  in  8  flag bits written by EXE.
- Ex_is_load  in  1  the EXE result is a load; data arrives later on Ld_data.
- Ld_valid  in  1  load data is returning this cycle.
- Ld_data  in  16  returned load data.
- Flush  in  1  kill the EXE descriptor so it is not captured.
- Src  out  16*NSRC  forwarded, zeroed or sign-extended operands; combinational.
- Stall  out  1  hold the upstream pipeline this cycle.
- Stall_cnt  out  CNTW  saturating count of cycles with Stall=1.

Behaviour:
- Entry fields: v, id, res[15:0], flg[7:0], fm[7:0], pend. Register encoding and the pair-to-half split (pair ids map to a high id and a low id; an 8-bit id has high id rR0) come from uISA.def.v.
- Reset: all v=0 and pend=0; state=RUN; Stall_cnt=0; Stall=0. Src then equals Rd_data with the zero and sign-extension rules applied.
- Low byte, non-F: take the youngest valid entry whose low id or high id equals the source low id, with low-id match winning inside an entry. Use the matching byte of res. If no entry matches, use Rd_data.
- High byte: same rule using the source high id, with high-id match winning inside an entry.
- Entries with id rR0, or with v=0, never match.
- F low byte: resolve each bit i independently. Scan from youngest entry to oldest; within an entry, fm[i]=1 gives flg[i]; otherwise an entry low id of rF gives res[i]. If nothing hits, use Rd_data[i].
- Output stage: source id rR0 forces the low byte to 0. Source id bit4=0 makes the high byte the sign extension of the low-byte bit7.
- Pending data: an entry with pend=1 supplies Ld_data when Ld_valid=1 in the same cycle. At that clock edge its res is written with Ld_data and pend is cleared. At most one pending entry exists.
- Hazard: true when a Rd_valid operand resolves any byte or bit to a pend=1 entry and Ld_valid=0.
- State RUN:
  - Stall = hazard.
  - Every clock, all stages shift by one and the oldest entry retires.
  - Stage 0 loads {Ex_valid & ~Flush & ~Stall, Ex_wr_id, Ex_result, Ex_flags, Ex_fmask, Ex_is_load}; pend = Ex_is_load.
  - If the oldest stage holds pend=1 and Ld_valid=0, go to WAIT instead of shifting.
- State WAIT:
  - Stall=1; all stages hold; EXE is not captured.
  - On Ld_valid=1: update the pending entry and return to RUN. The shift resumes on the following cycle.
- Stall_cnt increments on every cycle with Stall=1 and saturates at all-ones.
- Flush during WAIT has no effect. Flush never cancels entries already captured.
- Rst_n assertion in any state returns to reset values immediately.

Decomposition:
- Register ids and the pair-to-half split functions go in the existing uISA.def.v shared definitions.
- The new state encoding RUN=1'b0 and WAIT=1'b1 goes in the same shared definitions.
- One sub-module: fwd_byte_sel, a combinational youngest-first priority mux over NSTAGE entries for one byte, with an F bit-merge mode. It is instantiated twice per operand.

Test Plan:
1. Reset, operand 0 = rA with Rd_data 16'h0080 -> Src0 = 16'hFF80, Stall = 0, Stall_cnt = 0.
2. EX writes rHL = 16'h1234 at cycle t:
   - cycles t+1 and t+2: read rL -> 16'h0034; read rH -> 16'h0012; read rHL -> 16'h1234.
   - cycle t+3: Rd_data is used.
3. Stage 1 holds rF res 16'h00A0; stage 0 has fm 8'h01 and flg 8'h01. Read rAF with Rd_data 16'h5555 -> Src = 16'h55A1.
4. EX load to rB at t; at t+1 read rB with Ld_valid=0 -> Stall=1. At t+2 Ld_valid=1 with Ld_data 16'h007F -> Stall=0 and Src = 16'h007F. Stall_cnt = 1.
5. Load reaches stage NSTAGE-1 with no data -> WAIT with all stages frozen. Rst_n pulsed low mid-WAIT -> state RUN, Stall = 0, all entries invalid.
6. EX writes rR0 = 16'hFFFF -> reading rR0 gives 16'h0000. Reading rA, with rA's high-side match disabled, returns Rd_data unchanged.

Source files
------------

// File: rtl/fwd_unit_pipe_pkg.sv
// Shared register-id definitions, pair-to-half split helpers, shadow-pipe
// entry layout and FSM encoding for the forwarding unit.
package fwd_unit_pipe_pkg;

   localparam logic [4:0] R_R0 = 5'd0;
   localparam logic [4:0] R_A  = 5'd1;
   localparam logic [4:0] R_F  = 5'd2;
   localparam logic [4:0] R_B  = 5'd3;
   localparam logic [4:0] R_C  = 5'd4;
   localparam logic [4:0] R_D  = 5'd5;
   localparam logic [4:0] R_E  = 5'd6;
   localparam logic [4:0] R_H  = 5'd7;
   localparam logic [4:0] R_L  = 5'd8;
   localparam logic [4:0] R_AF = 5'd16;
   localparam logic [4:0] R_BC = 5'd17;
   localparam logic [4:0] R_DE = 5'd18;
   localparam logic [4:0] R_HL = 5'd19;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } fwd_state_e;

   typedef struct packed {
      logic        v;
      logic [4:0]  id;
      logic [15:0] res;
      logic [7:0]  flg;
      logic [7:0]  fm;
      logic        pend;
   } fwd_entry_t;

   // 8-bit ids have no high half; undefined pair codes split to rR0/rR0.
   function automatic logic [4:0] hi_id(input logic [4:0] id);
      case (id)
         R_AF:    hi_id = R_A;
         R_BC:    hi_id = R_B;
         R_DE:    hi_id = R_D;
         R_HL:    hi_id = R_H;
         default: hi_id = R_R0;
      endcase
   endfunction

   function automatic logic [4:0] lo_id(input logic [4:0] id);
      case (id)
         R_AF:    lo_id = R_F;
         R_BC:    lo_id = R_C;
         R_DE:    lo_id = R_E;
         R_HL:    lo_id = R_L;
         default: lo_id = id[4] ? R_R0 : id;
      endcase
   endfunction

endpackage

// File: rtl/fwd_unit_pipe_byte_sel.sv
// Youngest-first priority mux over the shadow pipe for one operand byte,
// with a per-bit merge mode for the flag register.
module fwd_byte_sel
   import fwd_unit_pipe_pkg::*;
#(
   parameter int NSTAGE = 2
) (
   input  fwd_entry_t [NSTAGE-1:0] entries,
   input  logic [4:0]              sel_id,
   input  logic                    hi_side,
   input  logic                    f_mode,
   input  logic [7:0]              rd_byte,
   input  logic [15:0]             ld_data,
   output logic [7:0]              byte_out,
   output logic                    pend_hit
);

   logic [15:0]       eff_res [NSTAGE];
   logic [NSTAGE-1:0] m_lo;
   logic [NSTAGE-1:0] m_hi;
   logic [NSTAGE-1:0] f_lo;
   logic [7:0]        pend_bits;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      assign eff_res[k] = entries[k].pend ? ld_data : entries[k].res;
      assign m_lo[k] = entries[k].v && (entries[k].id != R_R0) && (sel_id != R_R0)
                       && (lo_id(entries[k].id) == sel_id);
      assign m_hi[k] = entries[k].v && (entries[k].id != R_R0) && (sel_id != R_R0)
                       && (hi_id(entries[k].id) == sel_id);
      assign f_lo[k] = entries[k].v && (lo_id(entries[k].id) == R_F);
   end

   // Walking oldest to youngest lets the youngest hit overwrite older ones.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      byte_out  = rd_byte;
      pend_hit  = 1'b0;
      pend_bits = '0;
      if (!f_mode) begin
         for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (m_lo[k] || m_hi[k]) begin
               byte_out = (hi_side ? m_hi[k] : !m_lo[k]) ? eff_res[k][15:8]
                                                         : eff_res[k][7:0];
               pend_hit = entries[k].pend;
            end
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
               if (entries[k].v && entries[k].fm[i]) begin
                  byte_out[i]  = entries[k].flg[i];
                  pend_bits[i] = entries[k].pend;
               end else if (f_lo[k]) begin
                  byte_out[i]  = eff_res[k][i];
                  pend_bits[i] = entries[k].pend;
               end
            end
         end
         pend_hit = |pend_bits;
      end
   end

endmodule

// File: rtl/fwd_unit_pipe.sv
// EXE-stage forwarding unit with its own shadow pipeline of write
// descriptors, load-use hazard detection and a stall-cycle counter.
module fwd_unit_pipe
   import fwd_unit_pipe_pkg::*;
#(
   parameter int NSRC   = 2,
   parameter int NSTAGE = 2,
   parameter int CNTW   = 16
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [5*NSRC-1:0]    Rd_id,
   input  logic [16*NSRC-1:0]   Rd_data,
   input  logic [NSRC-1:0]      Rd_valid,
   input  logic                 Ex_valid,
   input  logic [4:0]           Ex_wr_id,
   input  logic [15:0]          Ex_result,
   input  logic [7:0]           Ex_flags,
   input  logic [7:0]           Ex_fmask,
   input  logic                 Ex_is_load,
   input  logic                 Ld_valid,
   input  logic [15:0]          Ld_data,
   input  logic                 Flush,
   output logic [16*NSRC-1:0]   Src,
   output logic                 Stall,
   output logic [CNTW-1:0]      Stall_cnt
);

   fwd_state_e              state, state_nxt;
   fwd_entry_t [NSTAGE-1:0] stages, stages_upd;
   fwd_entry_t              cap;
   logic [NSRC-1:0]         pend_dep;
   logic                    hazard;
   logic                    shift_en;

   for (genvar n = 0; n < NSRC; n++) begin : g_src
      logic [4:0] s_id, s_lo, s_hi;
      logic [7:0] lo_byte, hi_byte, lo_out;
      logic       lo_pend, hi_pend;

      assign s_id = Rd_id[5*n +: 5];
      assign s_lo = lo_id(s_id);
      assign s_hi = hi_id(s_id);

      fwd_byte_sel #(.NSTAGE(NSTAGE)) u_lo (
         .entries  (stages),
         .sel_id   (s_lo),
         .hi_side  (1'b0),
         .f_mode   (s_lo == R_F),
         .rd_byte  (Rd_data[16*n +: 8]),
         .ld_data  (Ld_data),
         .byte_out (lo_byte),
         .pend_hit (lo_pend)
      );

      fwd_byte_sel #(.NSTAGE(NSTAGE)) u_hi (
         .entries  (stages),
         .sel_id   (s_hi),
         .hi_side  (1'b1),
         .f_mode   (1'b0),
         .rd_byte  (Rd_data[16*n+8 +: 8]),
         .ld_data  (Ld_data),
         .byte_out (hi_byte),
         .pend_hit (hi_pend)
      );

      assign lo_out          = (s_id == R_R0) ? 8'h00 : lo_byte;
      assign Src[16*n +: 16] = {s_id[4] ? hi_byte : {8{lo_out[7]}}, lo_out};
      assign pend_dep[n]     = lo_pend | hi_pend;
   end

   assign hazard = (|(pend_dep & Rd_valid)) & ~Ld_valid;

   // Returning load data lands in the pending entry wherever it sits.
   always_comb begin
      for (int k = 0; k < NSTAGE; k++) begin
         stages_upd[k] = stages[k];
         if (Ld_valid && stages[k].pend) begin
            stages_upd[k].res  = Ld_data;
            stages_upd[k].pend = 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      Stall     = 1'b0;
      shift_en  = 1'b0;
      case (state)
         ST_RUN: begin
            Stall = hazard;
            if (stages[NSTAGE-1].pend && !Ld_valid) state_nxt = ST_WAIT;
            else                                    shift_en  = 1'b1;
         end
         ST_WAIT: begin
            Stall = 1'b1;
            if (Ld_valid) state_nxt = ST_RUN;
         end
      endcase
   end

   // A killed or stalled EXE slot enters as a bubble that can never go pending.
   always_comb begin
      cap      = '0;
      cap.v    = Ex_valid & ~Flush & ~Stall;
      cap.id   = Ex_wr_id;
      cap.res  = Ex_result;
      cap.flg  = Ex_flags;
      cap.fm   = Ex_fmask;
      cap.pend = Ex_is_load & cap.v;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= ST_RUN;
         // NOTE: the shadow pipe is a handful of flops, so whole entries are
         // reset and no X can reach the forwarding muxes.
         stages    <= '0;
         Stall_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the
         // pre-edge value of its neighbour.
         state <= state_nxt;
         if (shift_en) begin
            stages[0] <= cap;
            for (int k = 1; k < NSTAGE; k++) stages[k] <= stages_upd[k-1];
         end else begin
            stages <= stages_upd;
         end
         if (Stall && (Stall_cnt != '1)) Stall_cnt <= Stall_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_fwd_unit_pipe.sv
// Directed bench for fwd_unit_pipe: a descriptor-level reference model is
// compared every cycle, plus hand-computed literal expectations.
module tb_fwd_unit_pipe;
   import fwd_unit_pipe_pkg::*;

   localparam int NSRC   = 2;
   localparam int NSTAGE = 2;
   localparam int CNTW   = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [5*NSRC-1:0]   rd_id;
   logic [16*NSRC-1:0]  rd_data;
   logic [NSRC-1:0]     rd_valid;
   logic                ex_valid, ex_is_load, ld_valid, flush;
   logic [4:0]          ex_wr_id;
   logic [15:0]         ex_result, ld_data;
   logic [7:0]          ex_flags, ex_fmask;
   logic [16*NSRC-1:0]  src;
   logic                stall;
   logic [CNTW-1:0]     stall_cnt;

   int tests = 0;
   int fails = 0;

   fwd_unit_pipe #(.NSRC(NSRC), .NSTAGE(NSTAGE), .CNTW(CNTW)) dut (
      .Clk(clk), .Rst_n(rst_n), .Rd_id(rd_id), .Rd_data(rd_data), .Rd_valid(rd_valid),
      .Ex_valid(ex_valid), .Ex_wr_id(ex_wr_id), .Ex_result(ex_result), .Ex_flags(ex_flags),
      .Ex_fmask(ex_fmask), .Ex_is_load(ex_is_load), .Ld_valid(ld_valid), .Ld_data(ld_data),
      .Flush(flush), .Src(src), .Stall(stall), .Stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      bit v; bit [4:0] id; bit [15:0] res; bit [7:0] flg; bit [7:0] fm; bit pend;
   } desc_t;

   desc_t           pipe [NSTAGE];
   bit              m_wait = 1'b0;
   logic [CNTW-1:0] m_cnt = '0;
   bit              m_stall_now;

   function automatic void split(input logic [4:0] id, output logic [4:0] h, output logic [4:0] l);
      h = R_R0; l = R_R0;
      case (id)
         R_AF: begin h = R_A; l = R_F; end
         R_BC: begin h = R_B; l = R_C; end
         R_DE: begin h = R_D; l = R_E; end
         R_HL: begin h = R_H; l = R_L; end
         default: if (!id[4]) l = id;
      endcase
   endfunction

   function automatic logic [15:0] live_res(input int k);
      return pipe[k].pend ? ld_data : pipe[k].res;
   endfunction

   function automatic void lookup_byte(input logic [4:0] sel, input bit want_hi, input logic [7:0] dflt,
                                       output logic [7:0] val, output bit dep);
      logic [4:0] eh, el;
      logic [15:0] r;
      val = dflt; dep = 1'b0;
      if (sel == R_R0) return;
      for (int k = 0; k < NSTAGE; k++) begin
         if (!pipe[k].v || pipe[k].id == R_R0) continue;
         split(pipe[k].id, eh, el);
         if (eh != sel && el != sel) continue;
         r = live_res(k);
         if (want_hi) val = (eh == sel) ? r[15:8] : r[7:0];
         else         val = (el == sel) ? r[7:0]  : r[15:8];
         dep = pipe[k].pend && !ld_valid;
         return;
      end
   endfunction

   function automatic void lookup_f(input logic [7:0] dflt, output logic [7:0] val, output bit dep);
      logic [4:0] eh, el;
      logic [15:0] r;
      dep = 1'b0;
      for (int i = 0; i < 8; i++) begin
         val[i] = dflt[i];
         for (int k = 0; k < NSTAGE; k++) begin
            if (!pipe[k].v) continue;
            split(pipe[k].id, eh, el);
            r = live_res(k);
            if (pipe[k].fm[i]) begin
               val[i] = pipe[k].flg[i]; dep |= pipe[k].pend && !ld_valid; break;
            end
            if (el == R_F) begin
               val[i] = r[i]; dep |= pipe[k].pend && !ld_valid; break;
            end
         end
      end
   endfunction

   function automatic void eval_op(input int n, output logic [15:0] val, output bit dep);
      logic [4:0] sid, sh, sl;
      logic [15:0] d;
      logic [7:0] lo, hi;
      bit dl, dh;
      sid = rd_id[5*n +: 5];
      d   = rd_data[16*n +: 16];
      split(sid, sh, sl);
      if (sl == R_F) lookup_f(d[7:0], lo, dl);
      else           lookup_byte(sl, 1'b0, d[7:0], lo, dl);
      lookup_byte(sh, 1'b1, d[15:8], hi, dh);
      if (sid == R_R0) lo = 8'h00;
      if (!sid[4])     hi = {8{lo[7]}};
      val = {hi, lo};
      dep = dl | dh;
   endfunction

   function automatic bit model_stall();
      logic [15:0] v;
      bit d;
      if (m_wait) return 1'b1;
      for (int n = 0; n < NSRC; n++) begin
         eval_op(n, v, d);
         if (d && rd_valid[n]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void resolve_load();
      for (int k = 0; k < NSTAGE; k++)
         if (pipe[k].pend && ld_valid) begin
            pipe[k].res  = ld_data;
            pipe[k].pend = 1'b0;
         end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTAGE; k++) pipe[k] = '0;
         m_wait = 1'b0;
         m_cnt  = '0;
      end else begin
         m_stall_now = model_stall();
         if (!m_wait) begin
            if (pipe[NSTAGE-1].pend && !ld_valid) m_wait = 1'b1;
            else begin
               resolve_load();
               for (int k = NSTAGE - 1; k > 0; k--) pipe[k] = pipe[k-1];
               pipe[0].v    = ex_valid && !flush && !m_stall_now;
               pipe[0].id   = ex_wr_id;
               pipe[0].res  = ex_result;
               pipe[0].flg  = ex_flags;
               pipe[0].fm   = ex_fmask;
               pipe[0].pend = pipe[0].v && ex_is_load;
            end
         end else if (ld_valid) begin
            resolve_load();
            m_wait = 1'b0;
         end
         if (m_stall_now && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [15:0] cmp_val;
   bit          cmp_dep;

   always @(negedge clk) begin
      if (rst_n) begin
         for (int n = 0; n < NSRC; n++) begin
            eval_op(n, cmp_val, cmp_dep);
            if (!cmp_dep) check($sformatf("cyc_src%0d", n), src[16*n +: 16], cmp_val);
         end
         check("cyc_stall", stall, model_stall());
         check("cyc_stall_cnt", stall_cnt, m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
      ex_valid = 0; ex_is_load = 0; ld_valid = 0; flush = 0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic set_op(input int n, input logic [4:0] id, input logic [15:0] d, input bit v);
      rd_id[5*n +: 5]    = id;
      rd_data[16*n +: 16] = d;
      rd_valid[n]        = v;
   endtask

   task automatic ex_write(input logic [4:0] id, input logic [15:0] r, input logic [7:0] f,
                           input logic [7:0] m, input bit ld);
      ex_valid = 1; ex_wr_id = id; ex_result = r; ex_flags = f; ex_fmask = m; ex_is_load = ld;
   endtask

   initial begin
      rd_id = '0; rd_data = '0; rd_valid = '0;
      ex_valid = 0; ex_wr_id = 0; ex_result = 0; ex_flags = 0; ex_fmask = 0; ex_is_load = 0;
      ld_valid = 0; ld_data = 0; flush = 0;
      set_op(0, R_A, 16'h0080, 1);
      set_op(1, R_R0, 16'h0000, 0);
      #2 rst_n = 0;
      settle();
      check("reset_src0", src[15:0], 16'hFF80);
      check("reset_src1", src[31:16], 16'h0000);
      check("reset_stall", stall, 1'b0);
      check("reset_cnt", stall_cnt, 0);
      @(posedge clk); #1 rst_n = 1;
      tick();

      // rHL write, then halves and pair read back from both stages
      ex_write(R_HL, 16'h1234, 8'h00, 8'h00, 0);
      tick();
      set_op(0, R_L, 16'h00EE, 1); set_op(1, R_H, 16'h00EE, 1);
      settle();
      check("hl_t1_rL", src[15:0], 16'h0034);
      check("hl_t1_rH", src[31:16], 16'h0012);
      tick();
      set_op(0, R_HL, 16'hBEEF, 1);
      settle();
      check("hl_t2_rHL", src[15:0], 16'h1234);
      check("hl_t2_rH", src[31:16], 16'h0012);
      tick();
      settle();
      check("hl_t3_rHL", src[15:0], 16'hBEEF);
      check("hl_t3_rH", src[31:16], 16'hFFEE);

      // youngest entry wins per byte
      ex_write(R_HL, 16'hABCD, 8'h00, 8'h00, 0);
      tick();
      ex_write(R_L, 16'h0056, 8'h00, 8'h00, 0);
      tick();
      set_op(0, R_HL, 16'h0000, 1); set_op(1, R_H, 16'h0000, 1);
      settle();
      check("young_rHL", src[15:0], 16'hAB56);
      check("young_rH", src[31:16], 16'hFFAB);
      tick();

      // F bit merge: flag mask from stage 0 over rF result in stage 1
      ex_write(R_F, 16'h00A0, 8'h00, 8'h00, 0);
      tick();
      ex_write(R_B, 16'h0033, 8'h01, 8'h01, 0);
      tick();
      set_op(0, R_AF, 16'h5555, 1); set_op(1, R_B, 16'h0000, 1);
      settle();
      check("fmerge_rAF", src[15:0], 16'h55A1);
      check("fmerge_rB", src[31:16], 16'h0033);
      tick();

      // flush kills the EXE slot only
      ex_write(R_C, 16'h0011, 8'h00, 8'h00, 0); flush = 1;
      tick();
      ex_write(R_D, 16'h0044, 8'h00, 8'h00, 0);
      tick();
      flush = 1;
      set_op(0, R_C, 16'h0022, 1); set_op(1, R_D, 16'h0000, 1);
      settle();
      check("flush_rC", src[15:0], 16'h0022);
      check("flush_keeps_rD", src[31:16], 16'h0044);
      tick();
      tick();

      // load-use hazard resolved by returning data
      set_op(0, R_B, 16'h0000, 0); set_op(1, R_R0, 16'h0000, 0);
      ex_write(R_B, 16'hDEAD, 8'h00, 8'h00, 1);
      tick();
      set_op(0, R_B, 16'h0000, 1);
      settle();
      check("lu_stall", stall, 1'b1);
      tick();
      ld_valid = 1; ld_data = 16'h007F;
      settle();
      check("lu_nostall", stall, 1'b0);
      check("lu_src", src[15:0], 16'h007F);
      check("lu_cnt", stall_cnt, 1);
      tick();
      set_op(0, R_B, 16'h0000, 0);

      // load reaches oldest stage, WAIT, data arrives in WAIT
      ex_write(R_D, 16'h0000, 8'h00, 8'h00, 1);
      tick();
      tick();
      tick();
      ld_valid = 1; ld_data = 16'h0042;
      set_op(0, R_D, 16'h0007, 1);
      settle();
      check("wait_stall", stall, 1'b1);
      check("wait_ld_src", src[15:0], 16'h0042);
      tick();
      settle();
      check("resume_stall", stall, 1'b0);
      check("resume_src", src[15:0], 16'h0042);
      check("resume_cnt", stall_cnt, 2);
      set_op(0, R_D, 16'h0007, 0);
      tick();

      // WAIT freezes EXE capture, counter saturates, reset mid-WAIT
      set_op(0, R_E, 16'h0005, 0);
      ex_write(R_E, 16'h0000, 8'h00, 8'h00, 1);
      tick();
      tick();
      tick();
      ex_write(R_C, 16'h0099, 8'h00, 8'h00, 0); flush = 1;
      set_op(1, R_C, 16'h0077, 1);
      settle();
      check("frz_stall", stall, 1'b1);
      check("frz_cnt", stall_cnt, 2);
      tick();
      settle();
      check("frz_rC", src[31:16], 16'h0077);
      check("frz_cnt2", stall_cnt, 3);
      repeat (16) tick();
      settle();
      check("sat_cnt", stall_cnt, 4'hF);
      check("sat_stall", stall, 1'b1);
      #2 rst_n = 0;
      #1;
      check("rst_mid_stall", stall, 1'b0);
      check("rst_mid_cnt", stall_cnt, 0);
      check("rst_mid_rE", src[15:0], 16'h0005);
      @(posedge clk); #1 rst_n = 1;
      set_op(0, R_E, 16'h0005, 1);
      settle();
      check("post_rst_stall", stall, 1'b0);
      check("post_rst_rE", src[15:0], 16'h0005);
      tick();

      // rR0 writes never forward and never leak into 8-bit high sides
      ex_write(R_R0, 16'hFFFF, 8'h00, 8'h00, 0);
      tick();
      set_op(0, R_R0, 16'h1234, 1); set_op(1, R_A, 16'h0012, 1);
      settle();
      check("r0_src", src[15:0], 16'h0000);
      check("r0_rA", src[31:16], 16'h0012);
      tick();
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
